// File: rtl/slink_phy_tx_serializer.sv
// Splits one wide link-layer payload into PhyWidth-bit PHY beats, LSB beat first, with a per-payload beat count.
// Optional SLINK_TX_SER_BEAT_CNT_EN adds saturating beat/payload handshake counters (beat_cnt_o, payload_cnt_o).
module slink_phy_tx_serializer #(
  parameter  int DataWidth = 256,
  parameter  int PhyWidth  = 32,
  localparam int NumBeats  = (DataWidth + PhyWidth - 1) / PhyWidth,
  localparam int CntWidth  = $clog2(NumBeats + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [CntWidth-1:0]  num_beats_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [PhyWidth-1:0]  data_out_o,
  output logic                 data_out_valid_o,
  input  logic                 data_out_ready_i,
  output logic                 busy_o
`ifdef SLINK_TX_SER_BEAT_CNT_EN
  ,
  output logic [31:0]          beat_cnt_o,
  output logic [31:0]          payload_cnt_o
`endif
);

  localparam int PadWidth = NumBeats * PhyWidth;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [PadWidth-1:0]   shift_q, shift_d;
  logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CntWidth-1:0]   len_q, len_d;
  logic                  beat_hs;
  logic                  is_last;
  logic                  accept;

  // Zero and oversized requests both mean "send the whole payload".
  function automatic logic [CntWidth-1:0] clamp_len(input logic [CntWidth-1:0] n);
    if (n == '0 || n > CntWidth'(NumBeats)) return CntWidth'(NumBeats);
    return n;
  endfunction

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;

    beat_hs      = (state_q == SEND) && data_out_ready_i;
    is_last      = (beat_cnt_q == len_q - CntWidth'(1));
    data_ready_o = !rst_i && ((state_q == IDLE) || (beat_hs && is_last));
    accept       = data_valid_i && data_ready_o;

    if (accept) begin
      state_d    = SEND;
      shift_d    = PadWidth'(data_i);
      beat_cnt_d = '0;
      len_d      = clamp_len(num_beats_i);
    end else if (beat_hs) begin
      if (is_last) begin
        state_d = IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + CntWidth'(1);
        shift_d    = shift_q >> PhyWidth;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

  assign data_out_o       = shift_q[PhyWidth-1:0];
  assign data_out_valid_o = (state_q == SEND);
  assign busy_o           = (state_q == SEND);

`ifdef SLINK_TX_SER_BEAT_CNT_EN
  logic [31:0] beat_tot_q, beat_tot_d;
  logic [31:0] payload_tot_q, payload_tot_d;

  // Both totals saturate at all-ones rather than wrapping.
  always_comb begin
    beat_tot_d    = beat_tot_q;
    payload_tot_d = payload_tot_q;
    if (beat_hs && beat_tot_q != 32'hFFFF_FFFF) beat_tot_d = beat_tot_q + 32'd1;
    if (accept && payload_tot_q != 32'hFFFF_FFFF) payload_tot_d = payload_tot_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_tot_q    <= '0;
      payload_tot_q <= '0;
    end else begin
      beat_tot_q    <= beat_tot_d;
      payload_tot_q <= payload_tot_d;
    end
  end

  assign beat_cnt_o    = beat_tot_q;
  assign payload_cnt_o = payload_tot_q;
`endif

endmodule

// File: tb/tb_slink_phy_tx_serializer.sv
// Scoreboard bench for slink_phy_tx_serializer: driver pushes expected beats on acceptance, monitor pops on beat handshakes.
module tb_slink_phy_tx_serializer;

  logic         clk;
  logic         rst_i;
  logic [255:0] data_i;
  logic [3:0]   num_beats_i;
  logic         data_valid_i;
  logic         data_ready_o;
  logic [31:0]  data_out_o;
  logic         data_out_valid_o;
  logic         data_out_ready_i;
  logic         busy_o;
`ifdef SLINK_TX_SER_BEAT_CNT_EN
  logic [31:0]  beat_cnt_o;
  logic [31:0]  payload_cnt_o;
`endif

  slink_phy_tx_serializer #(.DataWidth(256), .PhyWidth(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .data_i           (data_i),
    .num_beats_i      (num_beats_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .data_out_o       (data_out_o),
    .data_out_valid_o (data_out_valid_o),
    .data_out_ready_i (data_out_ready_i),
    .busy_o           (busy_o)
`ifdef SLINK_TX_SER_BEAT_CNT_EN
    ,
    .beat_cnt_o       (beat_cnt_o),
    .payload_cnt_o    (payload_cnt_o)
`endif
  );

  logic [31:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int hs_count   = 0;
  int last_hs_cyc = 0;
  int acc_cyc    = 0;
  int ready_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Ready generator: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    int ph;
    logic [3:0] pat;
    ph = 0;
    pat = 4'b1001;
    data_out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          data_out_ready_i = pat[3 - ph];
          ph = (ph + 1) % 4;
        end
        2: data_out_ready_i = 1'($urandom_range(0, 1));
        default: data_out_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: compares every beat handshake against the scoreboard queue.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst_i) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 256'(data_out_valid_o), 256'(1'b1));
          check("hold_data", 256'(data_out_o), 256'(prev_data));
        end
        if (data_out_valid_o && data_out_ready_i) begin
          hs_count++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL extra_beat: got %0h expected no beat (cycle %0d)", data_out_o, cyc);
          end else begin
            check("beat", 256'(data_out_o), 256'(exp_q.pop_front()));
          end
        end else if (exp_q.size() == 0) begin
          check("idle_valid", 256'(data_out_valid_o), 256'(1'b0));
          check("idle_busy", 256'(busy_o), 256'(1'b0));
        end
        prev_stall = data_out_valid_o && !data_out_ready_i;
        prev_data  = data_out_o;
      end
    end
  end

  function automatic logic [255:0] rand_payload();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Offer a payload and hold it until accepted; record its expected beats at acceptance.
  task automatic send(input logic [255:0] d, input logic [3:0] nb);
    bit ok;
    int n;
    ok = 0;
    data_i       = d;
    num_beats_i  = nb;
    data_valid_i = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (data_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got no data_ready_o expected acceptance");
    end else begin
      n = (nb == 0 || nb > 8) ? 8 : int'(nb);
      for (int k = 0; k < n; k++) exp_q.push_back(d[k*32 +: 32]);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] pat;
    int first_acc;
    int h0;
    bit ok;

    // Reset with a payload offered: nothing may be accepted.
    rst_i        = 1'b1;
    data_valid_i = 1'b1;
    data_i       = rand_payload();
    num_beats_i  = 4'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 256'(data_ready_o), 256'(1'b0));
    end
    @(posedge clk);
    #1;
    rst_i        = 1'b0;
    data_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 256'(data_ready_o), 256'(1'b1));
    check("post_rst_valid", 256'(data_out_valid_o), 256'(1'b0));
    check("post_rst_busy", 256'(busy_o), 256'(1'b0));
    check("post_rst_data", 256'(data_out_o), 256'(0));
    @(posedge clk);
    #1;

    // Full payload, word k = k+1, with first-beat latency and no gaps.
    for (int k = 0; k < 8; k++) pat[k*32 +: 32] = 32'(k + 1);
    send(pat, 4'd0);
    idle();
    drain();
    check("full_span", 256'(last_hs_cyc - acc_cyc), 256'(8));

    // Short and clamped payloads.
    send(rand_payload(), 4'd3);
    idle();
    drain();
    check("short_span", 256'(last_hs_cyc - acc_cyc), 256'(3));
    send(rand_payload(), 4'd9);
    idle();
    drain();
    check("clamp_span", 256'(last_hs_cyc - acc_cyc), 256'(8));

    // Backpressure pattern 1,0,0,1.
    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      send(rand_payload(), 4'($urandom_range(0, 9)));
    end
    idle();
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back: second payload taken on the first one's last beat.
    send(rand_payload(), 4'd0);
    first_acc = acc_cyc;
    send(rand_payload(), 4'd0);
    idle();
    drain();
    check("b2b_span", 256'(last_hs_cyc - first_acc), 256'(16));

    // Reset in the middle of a payload.
    h0 = hs_count;
    send(rand_payload(), 4'd0);
    idle();
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      if (hs_count >= h0 + 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      #2;
    end
    check("mid_wait", 256'(ok), 256'(1));
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 256'(data_ready_o), 256'(1'b0));
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2;
    check("mid_rst_valid", 256'(data_out_valid_o), 256'(1'b0));
    check("mid_rst_busy", 256'(busy_o), 256'(1'b0));
`ifdef SLINK_TX_SER_BEAT_CNT_EN
    check("beat_cnt_rst", 256'(beat_cnt_o), 256'(0));
    check("payload_cnt_rst", 256'(payload_cnt_o), 256'(0));
`endif
    @(posedge clk);
    #1;
    send(rand_payload(), 4'd0);
    idle();
    drain();
    check("restart_span", 256'(last_hs_cyc - acc_cyc), 256'(8));
`ifdef SLINK_TX_SER_BEAT_CNT_EN
    check("beat_cnt_full", 256'(beat_cnt_o), 256'(8));
    check("payload_cnt_full", 256'(payload_cnt_o), 256'(1));
`endif

    // Randomized traffic with random backpressure and gaps.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(rand_payload(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
